// File: rtl/qram_bank_sdram_pkg.sv
// Shared definitions for the QRAM bank: FSM encoding, read-latency limits
// and the address-replicated shake mask.
package qram_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ADDR      = 3'd1,
    ST_WRITE     = 3'd2,
    ST_READ_WAIT = 3'd3,
    ST_RESP      = 3'd4
  } qram_state_e;

  localparam int READ_LATENCY_MIN = 1;
  localparam int READ_LATENCY_MAX = 15;
  localparam int CNT_W            = 4;

  // Address bits repeated LSB-first across the word; caller truncates to DataWidth.
  function automatic logic [63:0] shake_mask(input logic [7:0] addr,
                                             input int        addr_w,
                                             input int        data_w);
    logic [63:0] m;
    m = '0;
    for (int i = 0; i < 64; i++) begin
      if (i < data_w) m[i] = addr[i % addr_w];
    end
    return m;
  endfunction

endpackage

// File: rtl/qram_bank_sdram_word_store.sv
// Word array with per-word Written/Shaken flags: one write port, one
// registered read port, everything cleared by the asynchronous reset.
module qram_word_store #(
  parameter int DataWidth = 8,
  parameter int AddrWidth = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_wr_en,
  input  logic [AddrWidth-1:0] i_wr_addr,
  input  logic [DataWidth-1:0] i_wr_data,
  input  logic                 i_wr_shake,
  input  logic                 i_rd_en,
  input  logic [AddrWidth-1:0] i_rd_addr,
  output logic [DataWidth-1:0] o_rd_data,
  output logic                 o_rd_written,
  output logic                 o_rd_shaken
);

  localparam int Depth = 1 << AddrWidth;

  logic [DataWidth-1:0] r_mem [Depth];
  logic [Depth-1:0]     r_written;
  logic [Depth-1:0]     r_shaken;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < Depth; i++) r_mem[i] <= '0;
      r_written <= '0;
      r_shaken  <= '0;
    end else if (i_wr_en) begin
      r_mem[i_wr_addr]     <= i_wr_data;
      r_written[i_wr_addr] <= 1'b1;
      r_shaken[i_wr_addr]  <= i_wr_shake;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_rd_data    <= '0;
      o_rd_written <= 1'b0;
      o_rd_shaken  <= 1'b0;
    end else if (i_rd_en) begin
      o_rd_data    <= r_mem[i_rd_addr];
      o_rd_written <= r_written[i_rd_addr];
      o_rd_shaken  <= r_shaken[i_rd_addr];
    end
  end

endmodule

// File: rtl/qram_bank_sdram.sv
// QRAM bank: single-outstanding command FSM in front of a word store, with
// optional address-XOR shaking on write and un-shaking on read.
module qram_bank_sdram
  import qram_pkg::*;
#(
  parameter int DataWidth   = 8,
  parameter int AddrWidth   = 4,
  parameter int ReadLatency = 2
) (
  input  logic                 DDRClockP,
  input  logic                 ResetN,
  input  logic                 CmdValid,
  output logic                 CmdReady,
  input  logic                 CmdWrite,
  input  logic [AddrWidth-1:0] CmdAddr,
  input  logic [DataWidth-1:0] CmdData,
  input  logic                 ShakeMode,
  output logic                 RspValid,
  input  logic                 RspReady,
  output logic                 RspWrite,
  output logic [AddrWidth-1:0] RspAddr,
  output logic [DataWidth-1:0] RspData,
  output logic                 RspEmpty
);

  localparam logic [CNT_W-1:0] LP_RD_LAT = CNT_W'(ReadLatency);

  qram_state_e          r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_write;
  logic [AddrWidth-1:0] r_addr;
  logic [DataWidth-1:0] r_data;
  logic                 r_shake;
  logic                 r_cmd_ready;
  logic                 r_rsp_valid;
  logic                 r_rsp_write;
  logic [AddrWidth-1:0] r_rsp_addr;
  logic [DataWidth-1:0] r_rsp_data;
  logic                 r_rsp_empty;

  logic [DataWidth-1:0] w_mask;
  logic [DataWidth-1:0] w_wr_data;
  logic                 w_wr_en;
  logic                 w_rd_en;
  logic [DataWidth-1:0] w_rd_data;
  logic                 w_rd_written;
  logic                 w_rd_shaken;

  assign w_mask    = DataWidth'(shake_mask(8'(r_addr), AddrWidth, DataWidth));
  assign w_wr_data = r_shake ? (r_data ^ w_mask) : r_data;
  assign w_wr_en   = (r_state == ST_WRITE);
  // The store's registered read lands one edge later, when the counter reaches 0.
  assign w_rd_en   = (r_state == ST_READ_WAIT) && (r_cnt == CNT_W'(1));

  qram_word_store #(
    .DataWidth(DataWidth),
    .AddrWidth(AddrWidth)
  ) u_store (
    .clk         (DDRClockP),
    .rst_n       (ResetN),
    .i_wr_en     (w_wr_en),
    .i_wr_addr   (r_addr),
    .i_wr_data   (w_wr_data),
    .i_wr_shake  (r_shake),
    .i_rd_en     (w_rd_en),
    .i_rd_addr   (r_addr),
    .o_rd_data   (w_rd_data),
    .o_rd_written(w_rd_written),
    .o_rd_shaken (w_rd_shaken)
  );

  always_ff @(posedge DDRClockP or negedge ResetN) begin
    if (!ResetN) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_write     <= 1'b0;
      r_addr      <= '0;
      r_data      <= '0;
      r_shake     <= 1'b0;
      r_cmd_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_write <= 1'b0;
      r_rsp_addr  <= '0;
      r_rsp_data  <= '0;
      r_rsp_empty <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (r_cmd_ready && CmdValid) begin
            r_write     <= CmdWrite;
            r_addr      <= CmdAddr;
            r_data      <= CmdData;
            r_shake     <= ShakeMode;
            r_cmd_ready <= 1'b0;
            r_state     <= ST_ADDR;
          end else begin
            r_cmd_ready <= 1'b1;
          end
        end
        ST_ADDR: begin
          if (r_write) begin
            r_state <= ST_WRITE;
          end else begin
            r_cnt   <= LP_RD_LAT;
            r_state <= ST_READ_WAIT;
          end
        end
        ST_WRITE: begin
          r_rsp_valid <= 1'b1;
          r_rsp_write <= 1'b1;
          r_rsp_addr  <= r_addr;
          r_rsp_data  <= '0;
          r_rsp_empty <= 1'b0;
          r_state     <= ST_RESP;
        end
        ST_READ_WAIT: begin
          if (r_cnt == '0) begin
            r_rsp_valid <= 1'b1;
            r_rsp_write <= 1'b0;
            r_rsp_addr  <= r_addr;
            r_rsp_empty <= ~w_rd_written;
            if (!w_rd_written)
              r_rsp_data <= '0;
            else
              r_rsp_data <= w_rd_shaken ? (w_rd_data ^ w_mask) : w_rd_data;
            r_state <= ST_RESP;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        ST_RESP: begin
          if (RspReady) begin
            r_rsp_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign CmdReady = r_cmd_ready;
  assign RspValid = r_rsp_valid;
  assign RspWrite = r_rsp_write;
  assign RspAddr  = r_rsp_addr;
  assign RspData  = r_rsp_data;
  assign RspEmpty = r_rsp_empty;

endmodule

// File: tb/tb_qram_bank_sdram.sv
// Bench for qram_bank_sdram: vector table through a scoreboard, plus
// hand-written back-pressure, reset-abort and ReadLatency=3 sequences.
module tb_qram_bank_sdram;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  always #5 clk = ~clk;

  // Default instance: DataWidth 8, AddrWidth 4, ReadLatency 2
  logic       cmd_valid = 1'b0, cmd_write = 1'b0, shake = 1'b0, rsp_ready = 1'b0;
  logic [3:0] cmd_addr = '0;
  logic [7:0] cmd_data = '0;
  logic       cmd_ready, rsp_valid, rsp_write, rsp_empty;
  logic [3:0] rsp_addr;
  logic [7:0] rsp_data;

  qram_bank_sdram dut (
    .DDRClockP(clk), .ResetN(rst_n),
    .CmdValid(cmd_valid), .CmdReady(cmd_ready), .CmdWrite(cmd_write),
    .CmdAddr(cmd_addr), .CmdData(cmd_data), .ShakeMode(shake),
    .RspValid(rsp_valid), .RspReady(rsp_ready), .RspWrite(rsp_write),
    .RspAddr(rsp_addr), .RspData(rsp_data), .RspEmpty(rsp_empty)
  );

  // Second instance: DataWidth 6, ReadLatency 3
  logic       c3_valid = 1'b0, c3_write = 1'b0, c3_shake = 1'b0, c3_rready = 1'b0;
  logic [3:0] c3_addr = '0;
  logic [5:0] c3_data = '0;
  logic       c3_ready, c3_rvalid, c3_rwrite, c3_rempty;
  logic [3:0] c3_raddr;
  logic [5:0] c3_rdata;

  qram_bank_sdram #(.DataWidth(6), .AddrWidth(4), .ReadLatency(3)) dut3 (
    .DDRClockP(clk), .ResetN(rst_n),
    .CmdValid(c3_valid), .CmdReady(c3_ready), .CmdWrite(c3_write),
    .CmdAddr(c3_addr), .CmdData(c3_data), .ShakeMode(c3_shake),
    .RspValid(c3_rvalid), .RspReady(c3_rready), .RspWrite(c3_rwrite),
    .RspAddr(c3_raddr), .RspData(c3_rdata), .RspEmpty(c3_rempty)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end else begin
      $display("ok   %s = 0x%0h", name, act);
    end
  endtask

  typedef struct {
    bit         wr;
    logic [3:0] addr;
    logic [7:0] data;
    bit         sh;
    logic [7:0] exp_data;
    bit         exp_empty;
    bit         chk_word;
    logic [7:0] exp_word;
  } vec_t;

  typedef struct {
    bit         wr;
    logic [3:0] addr;
    logic [7:0] data;
    bit         empty;
    int         lat;
  } rsp_t;

  vec_t vecs[10];
  rsp_t sb[$];

  // Drive one command on the default instance; lat = edges from accept to RspValid.
  task automatic run_cmd(input bit wr, input logic [3:0] a, input logic [7:0] d,
                         input bit sh, output int lat, output bit to);
    int n;
    to = 1'b0;
    lat = 0;
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    if (!cmd_ready) begin to = 1'b1; return; end
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_data = d; shake = sh;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    while (!rsp_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    to = !rsp_valid;
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  initial begin
    int  lat;
    bit  to;
    rsp_t e;
    logic [3:0]  h_addr;
    logic [7:0]  h_data;

    vecs[0] = '{1, 4'h5, 8'hA3, 1, 8'h00, 0, 1, 8'hF6};
    vecs[1] = '{0, 4'h5, 8'h00, 0, 8'hA3, 0, 0, 8'h00};
    vecs[2] = '{0, 4'h2, 8'h00, 0, 8'h00, 1, 0, 8'h00};
    vecs[3] = '{1, 4'h7, 8'h3C, 1, 8'h00, 0, 1, 8'h4B};
    vecs[4] = '{1, 4'h7, 8'h3C, 0, 8'h00, 0, 1, 8'h3C};
    vecs[5] = '{0, 4'h7, 8'h00, 0, 8'h3C, 0, 0, 8'h00};
    vecs[6] = '{1, 4'h0, 8'hFF, 1, 8'h00, 0, 1, 8'hFF};
    vecs[7] = '{0, 4'h0, 8'h00, 0, 8'hFF, 0, 0, 8'h00};
    vecs[8] = '{1, 4'hF, 8'h12, 0, 8'h00, 0, 1, 8'h12};
    vecs[9] = '{0, 4'hF, 8'h00, 0, 8'h12, 0, 0, 8'h00};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_addr", rsp_addr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("cmd_ready_after_release", cmd_ready, 1);

    // ReadLatency=3 instance, DataWidth 6: shake mask for addr 0xB is 0x3B
    @(negedge clk);
    c3_valid = 1'b1; c3_write = 1'b1; c3_addr = 4'hB; c3_data = 6'h2A; c3_shake = 1'b1;
    @(posedge clk); #1;
    c3_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("c3_wr_valid", c3_rvalid, 1);
    chk("c3_word", 64'(dut3.u_store.r_mem[11]), 64'h11);
    c3_rready = 1'b1;
    @(posedge clk); #1;
    c3_rready = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    c3_valid = 1'b1; c3_write = 1'b0; c3_addr = 4'hB;
    @(posedge clk); #1;
    c3_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      chk($sformatf("c3_rd_valid_low_edge%0d", k), c3_rvalid, 0);
    end
    @(posedge clk); #1;
    chk("c3_rd_valid_edge5", c3_rvalid, 1);
    chk("c3_rd_data", c3_rdata, 6'h2A);
    chk("c3_rd_empty", c3_rempty, 0);
    c3_rready = 1'b1;
    @(posedge clk); #1;
    c3_rready = 1'b0;

    // Vector table through the scoreboard
    for (int i = 0; i < 10; i++) begin
      sb.push_back('{vecs[i].wr, vecs[i].addr,
                     vecs[i].wr ? 8'h00 : vecs[i].exp_data,
                     vecs[i].wr ? 1'b0 : vecs[i].exp_empty,
                     vecs[i].wr ? 2 : 4});
      run_cmd(vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].sh, lat, to);
      if (to) begin
        chk($sformatf("v%0d_timeout", i), 1, 0);
        void'(sb.pop_front());
        continue;
      end
      e = sb.pop_front();
      chk($sformatf("v%0d_latency", i), 64'(lat), 64'(e.lat));
      chk($sformatf("v%0d_rsp_write", i), rsp_write, e.wr);
      chk($sformatf("v%0d_rsp_addr", i), rsp_addr, e.addr);
      chk($sformatf("v%0d_rsp_data", i), rsp_data, e.data);
      chk($sformatf("v%0d_rsp_empty", i), rsp_empty, e.empty);
      handshake();
      if (vecs[i].chk_word)
        chk($sformatf("v%0d_word", i), 64'(dut.u_store.r_mem[vecs[i].addr]), 64'(vecs[i].exp_word));
    end

    // Back-pressure: RspReady low 3 cycles with a competing command held valid
    run_cmd(0, 4'h5, 8'h00, 0, lat, to);
    if (to) chk("bp_timeout", 1, 0);
    h_addr = rsp_addr;
    h_data = rsp_data;
    chk("bp_data", rsp_data, 8'hA3);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'h5; cmd_data = 8'h00; shake = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk($sformatf("bp_valid_%0d", k), rsp_valid, 1);
      chk($sformatf("bp_addr_%0d", k), rsp_addr, h_addr);
      chk($sformatf("bp_data_%0d", k), rsp_data, h_data);
      chk($sformatf("bp_cmd_ready_%0d", k), cmd_ready, 0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    cmd_valid = 1'b0;
    chk("bp_after_hs_valid", rsp_valid, 0);
    chk("bp_after_hs_cmd_ready", cmd_ready, 0);
    @(posedge clk); #1;
    chk("bp_cmd_ready_next", cmd_ready, 1);
    chk("bp_word_untouched", 64'(dut.u_store.r_mem[5]), 64'hF6);

    // Reset asserted during READ_WAIT
    run_cmd(1, 4'h9, 8'h44, 0, lat, to);
    if (to) chk("ra_wr_timeout", 1, 0);
    handshake();
    @(negedge clk);
    while (!cmd_ready) @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 4'h9;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("ra_cmd_ready", cmd_ready, 0);
    chk("ra_rsp_valid", rsp_valid, 0);
    chk("ra_word_cleared", 64'(dut.u_store.r_mem[9]), 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_cmd(0, 4'h9, 8'h00, 0, lat, to);
    if (to) chk("ra_rd_timeout", 1, 0);
    chk("ra_rd_empty", rsp_empty, 1);
    chk("ra_rd_data", rsp_data, 0);
    chk("ra_rd_addr", rsp_addr, 4'h9);
    handshake();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/qram_bank_sdram.md
Name: qram_bank_sdram

Overview:
Parametrised successor to the single-cell QRAM store. It holds a bank of 2^AddrWidth data words, each DataWidth bits, and serves one command at a time through a valid/ready command port and a valid/ready response port. An optional per-write "shake" mode stores each word XOR-coupled with its own address and un-couples it on read. It sits between the SDRAM-side clocking logic and the QRAM consumers.

Parameters:
DataWidth, 8, bits per stored word (range 1..64)
AddrWidth, 4, address bits; depth = 2^AddrWidth (range 1..8)
ReadLatency, 2, wait cycles between address phase and read response (range 1..15)

Ports:
DDRClockP  input  1  sole clock; rising edge only
ResetN  input  1  asynchronous, active-low reset
CmdValid  input  1  command present
CmdReady  output  1  bank can accept a command
CmdWrite  input  1  1 = write, 0 = read
CmdAddr  input  AddrWidth  target word
CmdData  input  DataWidth  write data (ignored on read)
ShakeMode  input  1  write only: store word XOR address mask
RspValid  output  1  response present
RspReady  input  1  consumer accepts response
RspWrite  output  1  response is a write acknowledge
RspAddr  output  AddrWidth  address of completed command
RspData  output  DataWidth  read data, un-shaken; 0 on write ack
RspEmpty  output  1  read targeted a never-written word

Behaviour:
- Reset (ResetN low, any time, mid-command included): FSM to IDLE; all words, Written bits and Shaken bits cleared; CmdReady=0, RspValid=0, RspWrite=0, RspAddr=0, RspData=0, RspEmpty=0. CmdReady rises at the first rising edge after release.
- FSM states: IDLE, ADDR, WRITE, READ_WAIT, RESP.
- IDLE: CmdReady=1. Accept on CmdValid&CmdReady; latch CmdWrite, CmdAddr, CmdData, ShakeMode; go to ADDR. CmdReady=0 in every other state; CmdValid is ignored there.
- ADDR (1 cycle): go to WRITE if write, else to READ_WAIT with counter=ReadLatency.
- WRITE (1 cycle): at the exit edge, word[addr] = data ^ mask if shake, else data. Written[addr]=1, Shaken[addr]=shake. Go to RESP with RspWrite=1, RspData=0, RspEmpty=0.
- READ_WAIT: counter decrements each edge. At the edge where counter==1: sample word[addr]. RspData = word ^ mask if Shaken[addr], else word. RspEmpty = ~Written[addr]; RspData forced to 0 when empty. Go to RESP.
- Mask = CmdAddr replicated LSB-first and truncated to DataWidth (DataWidth 8, AddrWidth 4, addr 0x5 -> 0x55; DataWidth 6, AddrWidth 4, addr 0xB -> 0x3B).
- Latency, counted in edges after the accepting edge: write RspValid is high after edge 2; read RspValid is high after edge 1+ReadLatency+1 (ReadLatency=2 -> edge 4).
- RESP: RspValid=1; all Rsp* outputs held stable until RspValid&RspReady, then return to IDLE. CmdReady rises the cycle after that handshake, so there is no back-to-back overlap.
- Overwriting a word replaces both its data and its Shaken bit. Written bits never clear except on reset.
- Read and write use the same latched address, so collisions cannot occur (single outstanding command).
- Registered outputs only; no combinational path from inputs to outputs.

Decomposition:
- Shared package qram_pkg: FSM state enum (3-bit encoding), function shake_mask(addr, DataWidth), ReadLatency legality constants (min 1, max 15; counter width 4).
- One sub-module: qram_word_store. It holds the 2^AddrWidth x DataWidth array plus the Written and Shaken bit vectors, with async clear, a single write port and a single registered read port. The FSM, counter and response registers stay in the top module.

Test Plan:
- Reset release, then write 0xA3 to addr 5 with shake=1 and read addr 5 -> write ack after 2 edges (RspWrite=1, RspData=0); read returns RspData=0xA3, RspEmpty=0; internal word = 0xF6.
- After reset, read addr 2 with no prior write -> RspData=0x00, RspEmpty=1, RspAddr=2.
- ReadLatency=3: read accepted at edge 0 -> RspValid low through edge 4, high after edge 5.
- Hold RspReady low 3 cycles during a read response while driving CmdValid=1 -> Rsp* outputs stable, CmdReady=0, no command accepted; CmdReady=1 one cycle after the handshake.
- Write 0x3C to addr 7 with shake=1, then 0x3C to addr 7 with shake=0, then read addr 7 -> 0x3C and internal word = 0x3C (Shaken bit cleared).
- Assert ResetN low during READ_WAIT -> outputs immediately take reset values; a subsequent read of the previously written addr returns RspEmpty=1, RspData=0.
